// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
// Holds the transmitter FSM state type, bit-index width and parameter limits,
// plus a helper that sizes the baud counter.
package uart_pkg;

  // Transmitter FSM states. PARITY is only reachable when UART_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Legal parameter ranges.
  localparam int unsigned MIN_DATA_BITS = 5;
  localparam int unsigned MAX_DATA_BITS = 9;
  localparam int unsigned MIN_CLKS_PER_BIT = 2;
  localparam int unsigned MAX_CLKS_PER_BIT = 65535;

  // The bit index walks data bits (up to 9) and stop bits (up to 2).
  localparam int unsigned IDX_W = 4;

  // Width of a down-counter that must hold values 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Reloadable baud-period counter for the UART transmitter.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-high reset; clears the counter
//   en       - counter runs while high, held at zero otherwise
//   load     - reload to a full bit period (used when a frame is accepted)
//   bit_tick - high in the last cycle of each bit period
// The counter reloads itself after every tick, so every bit, and therefore every
// FSM state entry, starts a fresh CLKS_PER_BIT period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic load,
  output logic bit_tick
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign bit_tick = en & ~load & (cnt_q == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits, each bit CLKS_PER_BIT clocks long.
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit after the data
// (parity = XOR of latched data XOR latched parity_odd).
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-high reset; aborts any frame in flight
//   tx_start   - send request, accepted only while idle
//   tx_data    - payload, latched on acceptance
//   parity_odd - 1 = odd parity, 0 = even; latched on acceptance
//   tx         - registered serial line, idle high
//   tx_busy    - high from acceptance until the tx_done edge
//   tx_done    - one-cycle pulse when the frame ends
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_odd,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT || CLKS_PER_BIT > MAX_CLKS_PER_BIT) begin : g_bad_clks
    $error("uart_tx_cfg: CLKS_PER_BIT out of range");
  end
  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS out of range");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load;
  logic                 bit_tick;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q != StIdle),
    .load    (load),
    .bit_tick(bit_tick)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          state_d = StStart;
          idx_d   = '0;
          shreg_d = tx_data;
          load    = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ parity_odd;
`endif
        end
      end
      StStart: begin
        if (bit_tick) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (idx_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
            idx_d = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          state_d = StStop;
          idx_d   = '0;
        end
      end
      StStop: begin
        if (bit_tick) begin
          if (idx_q == LAST_STOP) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // Output logic, computed from the upcoming state so tx changes on the entry edge.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != StIdle);
    done_d = (state_q == StStop) && (state_d == StIdle);
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per bit period; the legal range SHALL be 2..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; the legal range SHALL be 5..9.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame; the legal values SHALL be 1 or 2.
REQ-004 clk  input  1  single clock for all logic; rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tx_start  input  1  request to send tx_data; sampled on the rising clk edge.
REQ-007 tx_data  input  DATA_BITS  frame payload; tx_data[0] is sent first.
REQ-008 parity_odd  input  1  selects parity sense: 1 = odd, 0 = even; used only with UART_TX_PARITY_EN.
REQ-009 tx  output  1  serial line; idle level is high.
REQ-010 tx_busy  output  1  high from request acceptance until tx_done.
REQ-011 tx_done  output  1  one-cycle pulse at end of frame.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 In IDLE with tx_start=1, the block SHALL latch tx_data and parity_odd, enter START, and raise tx_busy on the same edge.
REQ-014 tx SHALL be driven from a register: 0 in START, the current data bit in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-015 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at every state entry.
REQ-016 DATA SHALL shift out DATA_BITS bits LSB first, with the bit index counting 0..DATA_BITS-1.
REQ-017 STOP SHALL last STOP_BITS*CLKS_PER_BIT cycles.
REQ-018 Leaving STOP, the block SHALL enter IDLE, pulse tx_done for 1 cycle, and drop tx_busy on the same edge.
REQ-019 tx_start asserted while tx_busy=1 SHALL be ignored; the request is not queued.
REQ-020 tx_start high on the cycle after the tx_done edge (IDLE) SHALL be accepted, giving back-to-back frames with no idle gap.
REQ-021 Changes to tx_data or parity_odd mid-frame SHALL NOT affect the frame in flight.
REQ-022 Total frame length SHALL be (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P = 1 with parity and 0 without.

Reset
REQ-023 Reset asserted SHALL immediately force: state IDLE, tx=1, tx_busy=0, tx_done=0, all counters 0.
REQ-024 Reset mid-frame SHALL abort the frame with no tx_done pulse; the first edge after deassertion SHALL be able to accept tx_start.

Configuration
REQ-025 With UART_TX_PARITY_EN defined, PARITY SHALL follow DATA and send the XOR of the latched data bits XOR latched parity_odd.
REQ-026 Without UART_TX_PARITY_EN, the PARITY state SHALL be unreachable, DATA SHALL go directly to STOP, and parity_odd SHALL be ignored.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state typedef and the shared bit-count and width constants.
REQ-028 Sub-module uart_baud_gen SHALL provide the reloadable baud counter and a bit_tick strobe, parametrised by CLKS_PER_BIT.
REQ-029 The block SHALL fit in roughly 150-250 RTL lines.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1)
REQ-030 Send 0xA5 without parity -> tx shows 0, 1,0,1,0,0,1,0,1, then 1, each held 16 cycles; tx_done pulses 160 cycles after acceptance.
REQ-031 Parity on, 0xA5 -> parity bit is 0 with parity_odd=0 and 1 with parity_odd=1; frame length 176 cycles.
REQ-032 Send 0x3C with tx_start held high through tx_done, then 0xC3 -> second start bit begins 1 cycle after the tx_done cycle; exactly 2 tx_done pulses.
REQ-033 Pulse tx_start with 0xFF at cycle 40 of a 0x00 frame -> request ignored; only 0x00 is sent; one tx_done.
REQ-034 Assert reset at cycle 70 of a frame -> tx=1 and tx_busy=0 immediately; no tx_done; a new 0x55 frame sends correctly after release.
REQ-035 STOP_BITS=2, DATA_BITS=5, send 0x15 -> 5 data bits 1,0,1,0,1, then stop high for 32 cycles; frame length 128 cycles.
